// File: rtl/imem_load_ctrl.sv
// Instruction-memory port owner: passes IF-stage fetches through when idle and
// packs loader bytes into little-endian words written from address 0 during a program load.
module imem_load_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter bit RESET_HOLD = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-2:0] load_words,
    input  logic                  load_abort,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic [31:0]           fetch_addr,
    output logic [31:0]           fetch_data,
    output logic                  fetch_valid,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata,
    output logic                  cpu_hold,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int WPW = ADDR_WIDTH - 1;
    // Word capacity of the memory, 2^(ADDR_WIDTH-2), expressed in load_words width.
    localparam logic [WPW-1:0] CAPACITY = {1'b1, {(ADDR_WIDTH-2){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e         state_q,      state_d;
    logic [WPW-1:0] word_ptr_q,   word_ptr_d;
    logic [WPW-1:0] word_count_q, word_count_d;
    logic [1:0]     byte_cnt_q,   byte_cnt_d;
    logic [31:0]    asm_q,        asm_d;
    logic           err_q,        err_d;
    logic           hold_q,       hold_d;

    logic           start_bad_s;
    logic           last_word_s;

    assign start_bad_s = (load_words == {WPW{1'b0}}) || (load_words > CAPACITY);
    assign last_word_s = (word_ptr_q == (word_count_q - {{(WPW-1){1'b0}}, 1'b1}));

    // Next-state, counter and assembly-register update.
    always_comb begin
        state_d      = state_q;
        word_ptr_d   = word_ptr_q;
        word_count_d = word_count_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        err_d        = 1'b0;
        hold_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (start_bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        word_count_d = load_words;
                        word_ptr_d   = {WPW{1'b0}};
                        byte_cnt_d   = 2'd0;
                        asm_d        = 32'h0000_0000;
                        state_d      = LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                // Abort beats a same-cycle byte; the partial word is thrown away.
                if (load_abort) begin
                    err_d      = 1'b1;
                    byte_cnt_d = 2'd0;
                    asm_d      = 32'h0000_0000;
                    state_d    = IDLE;
                end else if (byte_valid) begin
                    asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            WRITE: begin
                if (load_abort) begin
                    err_d      = 1'b1;
                    byte_cnt_d = 2'd0;
                    asm_d      = 32'h0000_0000;
                    state_d    = IDLE;
                end else if (last_word_s) begin
                    state_d = FLUSH;
                end else begin
                    word_ptr_d = word_ptr_q + {{(WPW-1){1'b0}}, 1'b1};
                    state_d    = LOAD;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; hold_q marks the first post-reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            word_ptr_q   <= {WPW{1'b0}};
            word_count_q <= {WPW{1'b0}};
            byte_cnt_q   <= 2'd0;
            asm_q        <= 32'h0000_0000;
            err_q        <= 1'b0;
            hold_q       <= RESET_HOLD;
        end else begin
            state_q      <= state_d;
            word_ptr_q   <= word_ptr_d;
            word_count_q <= word_count_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            err_q        <= err_d;
            hold_q       <= hold_d;
        end
    end

    // Port muxing: fetch passthrough in IDLE, loader view of the memory otherwise.
    always_comb begin
        fetch_valid = 1'b0;
        fetch_data  = 32'h0000_0000;
        mem_addr    = {{(31-ADDR_WIDTH){1'b0}}, word_ptr_q, 2'b00};
        mem_we      = 1'b0;
        byte_ready  = 1'b0;
        load_done   = 1'b0;

        case (state_q)
            IDLE: begin
                fetch_valid = 1'b1;
                fetch_data  = mem_rdata;
                mem_addr    = fetch_addr;
            end
            LOAD: begin
                byte_ready = 1'b1;
            end
            WRITE: begin
                mem_we = ~load_abort & ~rst;
            end
            FLUSH: begin
                load_done = 1'b1;
            end
            default: begin
                fetch_valid = 1'b0;
            end
        endcase

        if (mem_we) begin
            mem_wdata = asm_q;
        end else begin
            mem_wdata = 32'h0000_0000;
        end
    end

    assign load_busy = (state_q != IDLE);
    assign cpu_hold  = load_busy | hold_q;
    assign load_err  = err_q;

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Owns the single port of the instruction memory and shares it between two users: the IF-stage fetch path and a byte-serial program loader (UART/debug bridge). On a load request the block holds the CPU, packs incoming bytes into little-endian 32-bit words, and writes them to sequential word addresses from 0. When the load finishes it releases the CPU. Outside a load, fetch passes straight through.

Parameters:
ADDR_WIDTH, 12, byte-address width of instruction memory; capacity = 2^(ADDR_WIDTH-2) words
RESET_HOLD, 1, 1 = cpu_hold also asserted in the cycle after rst deasserts; 0 = not asserted

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
load_start  in  1  single-cycle request to begin a program load
load_words  in  ADDR_WIDTH-1  number of words to load; sampled on load_start
load_abort  in  1  cancels an in-progress load
byte_valid  in  1  loader byte available
byte_data  in  8  loader byte
byte_ready  out  1  block accepts byte this cycle
fetch_addr  in  32  IF-stage byte address
fetch_data  out  32  instruction to IF stage
fetch_valid  out  1  fetch_data is valid for fetch_addr
mem_addr  out  32  address to instruction memory
mem_wdata  out  32  write data to instruction memory
mem_we  out  1  memory write enable, one cycle per word
mem_rdata  in  32  memory read data (combinational read)
cpu_hold  out  1  stall/hold request to pipeline
load_busy  out  1  high in any state other than IDLE
load_done  out  1  one-cycle pulse on successful completion
load_err  out  1  one-cycle pulse on rejected start or abort

Behaviour:
- Clock/reset: one clock `clk`; `rst` is synchronous, active-high.
- States: IDLE, LOAD, WRITE, FLUSH. Counters: word_ptr (ADDR_WIDTH-1 bits), byte_cnt (2 bits). Also word_count latch and a 32-bit assembly register.
- Reset: state=IDLE, word_ptr=0, byte_cnt=0, assembly reg=0, mem_we=0, byte_ready=0, load_done=0, load_err=0.
- Reset, cpu_hold: 0, except 1 for the first post-reset cycle when RESET_HOLD=1.
- Reset mid-load: abandons the load immediately. Words already written stay in memory. No done/err pulse.
- IDLE, outputs: mem_addr=fetch_addr; fetch_data=mem_rdata (combinational); fetch_valid=1; cpu_hold=0; byte_ready=0; mem_we=0.
- IDLE + load_start, rejected: if load_words==0 or load_words > 2^(ADDR_WIDTH-2), pulse load_err next cycle and stay IDLE.
- IDLE + load_start, accepted: latch word_count, clear word_ptr/byte_cnt, go to LOAD.
- load_start is ignored outside IDLE.
- All non-IDLE states: fetch_valid=0, cpu_hold=1, load_busy=1, mem_addr={word_ptr,2'b00} zero-extended to 32 bits.
- LOAD, handshake: byte_ready=1. A handshake is byte_valid & byte_ready.
- LOAD, byte packing: on a handshake, byte_data goes to assembly lane byte_cnt (first byte → [7:0], fourth → [31:24]), then byte_cnt increments.
- LOAD → WRITE: on the handshake with byte_cnt==3.
- WRITE (exactly 1 cycle): byte_ready=0; mem_we=1; mem_wdata=assembly reg; mem_addr=word_ptr*4.
- WRITE exit: if word_ptr==word_count-1, go to FLUSH; else increment word_ptr and return to LOAD.
- FLUSH (exactly 1 cycle): load_done=1, cpu_hold=1, mem_we=0. Next state is IDLE. The first post-load fetch therefore sees the new contents.
- load_abort in LOAD or WRITE: takes priority over a same-cycle handshake and over the write. The write in that cycle is suppressed (mem_we=0). Discard the partial word, pulse load_err next cycle, go to IDLE. Words already written are retained.
- load_abort in IDLE or FLUSH: no effect.
- Simultaneous rst and anything: rst wins.
- byte_valid without ready: no state change. Bytes are never consumed outside LOAD.
- word_ptr never wraps: the load_words range check guarantees this.
- mem_wdata is 0 whenever mem_we=0.

Test Plan:
- Fetch passthrough: idle, fetch_addr=0x10, mem_rdata=0x00A00093 → mem_addr=0x10, fetch_data=0x00A00093, fetch_valid=1, cpu_hold=0.
- Single-word load:
  - Stimulus: load_words=1; bytes 0x93,0x00,0xA0,0x00 with byte_valid held.
  - Response: one mem_we pulse with mem_addr=0, wdata=0x00A00093.
  - Response: load_done pulses the cycle after the write; cpu_hold drops the following cycle.
- Multi-word with backpressure gaps:
  - Stimulus: load_words=3; random byte_valid gaps.
  - Response: writes at addresses 0x0, 0x4, 0x8 with the correct words.
  - Response: byte_ready=0 in each WRITE cycle; load_busy high throughout.
- Rejected start: load_words=0, then load_words=1025 (ADDR_WIDTH=12, capacity 1024) → load_err pulse each time, no mem_we, state stays IDLE.
- Abort:
  - Stimulus: load_words=4; abort after word 1 plus 2 bytes.
  - Response: word 0 written; load_err pulses; no further mem_we; IDLE restored (fetch_valid=1).
  - Response: a fresh load then starts at address 0.
- Reset mid-load: rst asserted during a WRITE cycle → next cycle mem_we=0, state IDLE; with RESET_HOLD=1, cpu_hold=1 for one cycle after rst drops, then 0.
